clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
Parametrised, runtime-programmable integer clock divider. It generalises the fixed half, quarter and one-third dividers into one block with selectable divide ratio N (0 = stopped, 1 to 2^WIDTH-1 = divide). All logic runs on the single rising edge of clk_in. The block drives a near-50% divided clock, a one-cycle tick strobe that downstream logic uses as a clock enable, and its internal count and active ratio for debug and observation.

Parameters:
WIDTH, 8, width of the divisor and the counter.
DIV_DEFAULT, 2, active divisor loaded at reset (0 to 2^WIDTH-1).

Ports:
clk_in  input  1  sole clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable; 0 freezes the divider.
div_val  input  WIDTH  new divisor value, sampled when div_load=1.
div_load  input  1  one-cycle request to stage div_val.
clk_out  output  1  divided clock (registered).
tick  output  1  one-cycle strobe per completed period (registered).
count  output  WIDTH  current phase counter (registered).
div_cur  output  WIDTH  active divisor D.
pend  output  1  a staged divisor is waiting for the next period boundary.

Behaviour:
- Reset (sync, high; overrides every other input in the same cycle, including mid-period): count=0, div_cur=DIV_DEFAULT, pend=0, tick=0, clk_out=(DIV_DEFAULT!=0).
- Let D = div_cur, H = (D+1)>>1 (integer). clk_out is high for ceil(D/2) cycles and low for floor(D/2) cycles.
- Counting (en=1, D>=1):
  - If count==D-1, count wraps to 0. This edge is a boundary.
  - Otherwise count increments by 1.
- Outputs after each edge are registered from the next state:
  - clk_out = (count_next < H_next).
  - tick = 1 only for the cycle following a boundary taken with en=1; otherwise 0.
- D=1: count stays 0, clk_out constantly 1, tick=1 on every enabled cycle.
- D=0 (stopped): count held at 0, clk_out=0, tick=0, regardless of en.
- en=0: count, clk_out and div_cur hold. tick drops to 0 after one edge. Staged loads are kept.
- Staging: div_load=1 writes div_val into the staging register and sets pend=1. If several loads arrive before a boundary, the last one wins.
- Apply: at a boundary, if pend=1 (or div_load=1 on that same edge, which takes priority), then div_cur<=staged value, count<=0, pend<=0, and clk_out is computed with the new H.
- If the current D==0, a staged value is applied on the edge after it is staged; en is not required for this.
- Applying a new value of 0 stops the divider at the boundary.
- div_cur changes only at reset or when a staged value is applied, never mid-period, so clk_out has no runt pulses.
- Arithmetic: count and div_cur are unsigned WIDTH bits. D-1 and H are computed in WIDTH bits. No overflow, because count never exceeds D-1.

Test Plan:
- Reset then D=4, en=1: count 0,1,2,3,0…; clk_out 1,1,0,0 repeating; tick high in the cycle where count=0 after each wrap (every 4th cycle).
- Load 3 at count=1 with D=4: pend=1, and D=4 finishes its period. After the wrap, div_cur=3, pend=0, and clk_out runs 1,1,0 repeating.
- Load 5 then load 7 before the boundary: only 7 is applied. The period is 7 cycles, clk_out high for 4 cycles and low for 3.
- Hold en=0 for 3 cycles at count=2, D=4: count stays 2, clk_out stays 0, tick=0. After en returns to 1, counting resumes at 3.
- Load 0: clk_out=0 and tick=0 after the boundary. Then load 1: div_cur=1 on the next edge, clk_out=1 and tick=1 every cycle.
- Assert reset mid-period with D=6 at count=4 and a pending load: count=0, div_cur=DIV_DEFAULT(2), pend=0, tick=0, clk_out=1. Then clk_out toggles every cycle.

Source files
------------

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider.
// A new divisor is staged with div_load and only takes effect at a period
// boundary, or on the next edge when the divider is stopped. This keeps
// clk_out free of runt pulses.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DIV_DEFAULT = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] stg, stg_next;
  logic [WIDTH-1:0] count_next, div_next, half_next;
  logic             pend_next, tick_next, clk_next, boundary;

  // Next-state logic: staging, counting, boundary detection and divisor apply
  always_comb begin
    count_next = count;
    div_next   = div_cur;
    stg_next   = stg;
    pend_next  = pend;
    boundary   = 1'b0;

    if (div_load) begin
      stg_next  = div_val;
      pend_next = 1'b1;
    end

    if (div_cur == '0) begin
      // Stopped: a value staged on an earlier edge is applied now, whatever en is.
      // A load arriving on this same edge stays staged for the next edge.
      count_next = '0;
      if (pend) begin
        div_next  = stg;
        pend_next = div_load;
      end
    end else if (en) begin
      if (count == div_cur - ONE) begin
        boundary   = 1'b1;
        count_next = '0;
        // A load on the boundary edge takes priority over the older staged value
        if (div_load) begin
          div_next  = div_val;
          pend_next = 1'b0;
        end else if (pend) begin
          div_next  = stg;
          pend_next = 1'b0;
        end
      end else begin
        count_next = count + ONE;
      end
    end

    // ceil(D/2) is computed without forming D+1, so it cannot overflow when D is all ones
    half_next = (div_next >> 1) + {{(WIDTH-1){1'b0}}, div_next[0]};
    clk_next  = (count_next < half_next);
    // Applying a divisor of 0 stops the divider, so that boundary produces no tick
    tick_next = boundary && (div_next != '0);
  end

  // State and registered outputs; reset has priority over every other input
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count   <= '0;
      div_cur <= DEF;
      stg     <= '0;
      pend    <= 1'b0;
      tick    <= 1'b0;
      clk_out <= (DEF != '0);
    end else begin
      count   <= count_next;
      div_cur <= div_next;
      stg     <= stg_next;
      pend    <= pend_next;
      tick    <= tick_next;
      clk_out <= clk_next;
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed, table-driven bench for clk_div_prog (WIDTH=8, DIV_DEFAULT=2).
module tb_clk_div_prog;

  logic       clk_in = 1'b0;
  logic       reset, en, div_load;
  logic [7:0] div_val;
  logic       clk_out, tick, pend;
  logic [7:0] count, div_cur;

  int n_pass  = 0;
  int n_total = 0;

  clk_div_prog #(.WIDTH(8), .DIV_DEFAULT(2)) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .div_val(div_val),
    .div_load(div_load), .clk_out(clk_out), .tick(tick), .count(count),
    .div_cur(div_cur), .pend(pend)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       rst, en, ld;
    logic [7:0] val;
    logic [7:0] cnt;
    logic       co, tk;
    logic [7:0] dv;
    logic       pd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit e, input bit l, input int val,
                              input int c, input bit co, input bit tk,
                              input int d, input bit p);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l; v.val = 8'(val);
    v.cnt = 8'(c); v.co = co; v.tk = tk; v.dv = 8'(d); v.pd = p;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input bit r, input bit e, input bit l, input int val);
    reset = r; en = e; div_load = l; div_val = 8'(val);
    @(posedge clk_in);
    #1;
  endtask

  // Safety net in case the simulation stalls
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hi, tk;
    reset = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;

    //             rst en ld val   cnt co tk div pd
    tbl.push_back(mk(1, 0, 0, 0,    0, 1, 0, 2, 0)); // reset state
    tbl.push_back(mk(0, 1, 1, 4,    1, 0, 0, 2, 1)); // stage 4 while D=2
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 4, 0)); // boundary applies 4
    tbl.push_back(mk(0, 1, 0, 0,    1, 1, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0,    2, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0,    3, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0,    1, 1, 0, 4, 0));
    tbl.push_back(mk(0, 1, 1, 3,    2, 0, 0, 4, 1)); // load 3 at count=1
    tbl.push_back(mk(0, 1, 0, 0,    3, 0, 0, 4, 1));
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 3, 0)); // D=3 applied
    tbl.push_back(mk(0, 1, 0, 0,    1, 1, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0,    2, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 3, 0));
    tbl.push_back(mk(0, 1, 1, 5,    1, 1, 0, 3, 1)); // load 5
    tbl.push_back(mk(0, 1, 1, 7,    2, 0, 0, 3, 1)); // then 7, last wins
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 7, 0));
    tbl.push_back(mk(0, 1, 0, 0,    1, 1, 0, 7, 0));
    tbl.push_back(mk(0, 1, 0, 0,    2, 1, 0, 7, 0));
    tbl.push_back(mk(0, 1, 0, 0,    3, 1, 0, 7, 0));
    tbl.push_back(mk(0, 1, 0, 0,    4, 0, 0, 7, 0));
    tbl.push_back(mk(0, 1, 0, 0,    5, 0, 0, 7, 0));
    tbl.push_back(mk(0, 1, 0, 0,    6, 0, 0, 7, 0));
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 7, 0));
    tbl.push_back(mk(0, 1, 1, 4,    1, 1, 0, 7, 1)); // back to D=4
    tbl.push_back(mk(0, 1, 0, 0,    2, 1, 0, 7, 1));
    tbl.push_back(mk(0, 1, 0, 0,    3, 1, 0, 7, 1));
    tbl.push_back(mk(0, 1, 0, 0,    4, 0, 0, 7, 1));
    tbl.push_back(mk(0, 1, 0, 0,    5, 0, 0, 7, 1));
    tbl.push_back(mk(0, 1, 0, 0,    6, 0, 0, 7, 1));
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0,    1, 1, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0,    2, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0,    2, 0, 0, 4, 0)); // en=0 x3 at count=2
    tbl.push_back(mk(0, 0, 0, 0,    2, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0,    2, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0,    3, 0, 0, 4, 0)); // resumes at 3
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 4, 0));
    tbl.push_back(mk(0, 1, 1, 0,    1, 1, 0, 4, 1)); // load 0
    tbl.push_back(mk(0, 1, 0, 0,    2, 0, 0, 4, 1));
    tbl.push_back(mk(0, 1, 0, 0,    3, 0, 0, 4, 1));
    tbl.push_back(mk(0, 1, 0, 0,    0, 0, 0, 0, 0)); // stopped, no tick
    tbl.push_back(mk(0, 1, 0, 0,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1,    0, 0, 0, 0, 1)); // stage 1 with en=0
    tbl.push_back(mk(0, 0, 0, 0,    0, 1, 0, 1, 0)); // applied without en
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 1, 0)); // D=1: tick every cycle
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 1, 0, 1, 0)); // en=0 drops tick
    tbl.push_back(mk(0, 1, 1, 6,    0, 1, 1, 6, 0)); // load on boundary edge
    tbl.push_back(mk(0, 1, 0, 0,    1, 1, 0, 6, 0));
    tbl.push_back(mk(0, 1, 0, 0,    2, 1, 0, 6, 0));
    tbl.push_back(mk(0, 1, 0, 0,    3, 0, 0, 6, 0));
    tbl.push_back(mk(0, 1, 1, 9,    4, 0, 0, 6, 1)); // pending at count=4
    tbl.push_back(mk(1, 1, 1, 5,    0, 1, 0, 2, 0)); // reset mid-period wins
    tbl.push_back(mk(0, 1, 0, 0,    1, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0,    0, 1, 1, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0,    1, 0, 0, 2, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].ld, int'(tbl[i].val));
      chk($sformatf("v%0d.count",   i), int'(count),   int'(tbl[i].cnt));
      chk($sformatf("v%0d.clk_out", i), int'(clk_out), int'(tbl[i].co));
      chk($sformatf("v%0d.tick",    i), int'(tick),    int'(tbl[i].tk));
      chk($sformatf("v%0d.div_cur", i), int'(div_cur), int'(tbl[i].dv));
      chk($sformatf("v%0d.pend",    i), int'(pend),    int'(tbl[i].pd));
    end

    // Staged load survives en=0, then largest divisor: high time must be 128 of 255
    drive(0, 0, 1, 255);
    chk("hold.pend", int'(pend), 1);
    chk("hold.count", int'(count), 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("hold.pend2", int'(pend), 1);
    chk("hold.div", int'(div_cur), 2);
    drive(0, 1, 0, 0);
    chk("d255.apply_div", int'(div_cur), 255);
    chk("d255.apply_tick", int'(tick), 1);
    chk("d255.apply_clk", int'(clk_out), 1);
    hi = 0; tk = 0;
    for (int c = 0; c < 255; c++) begin
      drive(0, 1, 0, 0);
      hi += int'(clk_out);
      tk += int'(tick);
    end
    chk("d255.high_cycles", hi, 128);
    chk("d255.ticks", tk, 1);
    chk("d255.wrap_count", int'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
